// File: rtl/tone_voice_mixer_if.sv
// Sample stream from the tone mixer to the audio codec serializer.
// master drives sample_data/sample_valid; slave returns sample_ready.
interface tone_voice_mixer_if #(
  parameter int unsigned OUT_W = 16
) ();

  logic signed [OUT_W-1:0] sample_data;
  logic                    sample_valid;
  logic                    sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/tone_voice_mixer.sv
// Tone voice mixer: one square-wave oscillator per key, mixed into a signed
// PCM sample at a fixed sample rate and offered on a valid/ready stream.
// Optional build macro MIXER_SAT_CLIP_EN: saturate the mix to the OUT_W range
// instead of two's-complement wrapping.
module tone_voice_mixer #(
  parameter int unsigned NUM_VOICES = 13,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned AMP        = 2048,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned SAMPLE_DIV = 1042
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CNT_W-1:0]      half_period [NUM_VOICES],
  output logic [NUM_VOICES-1:0] square_out,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [7:0]            overrun_cnt,
  tone_voice_mixer_if.master    sample_bus
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

`ifdef MIXER_SAT_CLIP_EN
  // Four guard bits keep up to 16 full-scale voices exact before clipping.
  localparam int unsigned ACC_W = OUT_W + 4;
  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_S = ~MAX_S;
`else
  // Wrapping keeps only the low OUT_W bits, which modular accumulation at
  // OUT_W already yields exactly.
  localparam int unsigned ACC_W = OUT_W;
`endif

  localparam logic signed [ACC_W-1:0] AMP_S = ACC_W'(AMP);

  typedef enum logic {StIdle, StHold} state_e;

  logic [CNT_W-1:0]        period_q [NUM_VOICES];
  logic [CNT_W-1:0]        cnt_q    [NUM_VOICES];
  logic [NUM_VOICES-1:0]   square_q;
  logic [NUM_VOICES-1:0]   active_q;
  logic [DIV_W-1:0]        div_q;
  logic                    tick;
  logic signed [ACC_W-1:0] sum;
  logic signed [OUT_W-1:0] mixed;
  logic signed [OUT_W-1:0] data_q;
  logic [7:0]              overrun_q;
  state_e                  state_q, state_d;
  logic                    load;
  logic                    drop;

  // Previous half-period per voice, used to detect key/scale changes.
  always_ff @(posedge clk) begin
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      period_q[v] <= half_period[v];
    end
  end

  // Per-voice half-period counter and phase bit; any change restarts low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        cnt_q[v] <= '0;
      end
      square_q <= '0;
      active_q <= '0;
    end else begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        active_q[v] <= (half_period[v] != '0);
        if (half_period[v] == '0 || half_period[v] != period_q[v]) begin
          cnt_q[v]    <= '0;
          square_q[v] <= 1'b0;
        end else if (cnt_q[v] == half_period[v] - CNT_W'(1)) begin
          cnt_q[v]    <= '0;
          square_q[v] <= ~square_q[v];
        end else begin
          cnt_q[v] <= cnt_q[v] + CNT_W'(1);
        end
      end
    end
  end

  assign square_out   = square_q;
  assign voice_active = active_q;

  // Sample-rate divider; tick on its last count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

  // Sum of active voices, +AMP when high and -AMP when low.
  always_comb begin
    sum = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      if (active_q[v]) begin
        sum = square_q[v] ? (sum + AMP_S) : (sum - AMP_S);
      end
    end
  end

`ifdef MIXER_SAT_CLIP_EN
  // Clamp the wide sum into the signed output range.
  always_comb begin
    if (sum > MAX_S) begin
      mixed = MAX_S[OUT_W-1:0];
    end else if (sum < MIN_S) begin
      mixed = MIN_S[OUT_W-1:0];
    end else begin
      mixed = sum[OUT_W-1:0];
    end
  end
`else
  assign mixed = sum;
`endif

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a tick always leaves a sample pending; a transfer without a
  // tick empties the slot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (tick) state_d = StHold;
      StHold: if (!tick && sample_bus.sample_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: load when the slot is free or being drained this cycle,
  // otherwise the new sample is dropped.
  always_comb begin
    sample_bus.sample_valid = (state_q == StHold);
    load = tick && ((state_q == StIdle) || sample_bus.sample_ready);
    drop = tick && (state_q == StHold) && !sample_bus.sample_ready;
  end

  // Sample register, held stable while waiting for the consumer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= mixed;
    end
  end

  // Saturating count of dropped samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun_q <= '0;
    end else if (drop && overrun_q != 8'hFF) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign sample_bus.sample_data = data_q;
  assign overrun_cnt            = overrun_q;

endmodule
